// File: rtl/ms_io_ports_pkg.sv
// ms_io_ports_pkg
// Shared definitions for the MaquinaSencilla I/O port block:
//   - port address map (5-bit dirport space)
//   - STATUS register bit positions
//   - is_scratch(): address decode helper for the eight scratch registers
package ms_io_ports_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_SCRATCH0 = 5'h00;
    localparam logic [ADDR_W-1:0] ADDR_SCRATCH7 = 5'h07;
    localparam logic [ADDR_W-1:0] ADDR_SW       = 5'h08;
    localparam logic [ADDR_W-1:0] ADDR_LED      = 5'h09;
    localparam logic [ADDR_W-1:0] ADDR_TIMER    = 5'h0A;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 5'h0B;
    localparam logic [ADDR_W-1:0] ADDR_TXDATA   = 5'h0C;
    localparam logic [ADDR_W-1:0] ADDR_TXCOUNT  = 5'h0D;

    localparam int STAT_TIMER_EXP = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_TX_EMPTY  = 2;
    localparam int STAT_TX_OVF    = 3;

    // Scratch registers occupy an aligned block of eight addresses, so a
    // match is "all bits above the block offset equal to the block base".
    function automatic logic is_scratch(input logic [ADDR_W-1:0] addr);
        return ((addr & ~ADDR_SCRATCH7) == ADDR_SCRATCH0);
    endfunction

endpackage

// File: rtl/ms_tx_fifo.sv
// ms_tx_fifo
// Byte FIFO feeding the TX valid/ready stream.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   push, push_data    enqueue request; ignored while full
//   pop                dequeue request; ignored while empty
//   full, empty        occupancy flags (combinational from count)
//   head               entry at the read pointer (valid when !empty)
//   count              occupancy 0..DEPTH
module ms_tx_fifo #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [7:0]    head,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == CW'(0));
    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;
    // Full is judged on the registered count, so a same-cycle pop never
    // makes room for a push.
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Next-state: storage, pointers (wrap naturally at DEPTH) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset to the empty state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ms_io_ports.sv
// ms_io_ports
// Memory-mapped I/O block for MaquinaSencilla: eight scratch registers,
// synchronized switch input, LED register, down-counting timer with expiry
// flag/irq, and a byte TX FIFO with valid/ready output.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   dirport, outport, we       CPU port address, write data, write strobe
//   inport                     CPU read data (combinational, no side effects)
//   sw_in / led_out            external switches in / LED register out
//   tx_data, tx_valid, tx_ready  byte stream from the TX FIFO
//   irq                        timer-expired status bit
module ms_io_ports
    import ms_io_ports_pkg::*;
#(
    parameter logic [15:0] REG0_INIT  = 16'd2,
    parameter logic [15:0] REG1_INIT  = 16'd4,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  dirport,
    input  logic [15:0] outport,
    input  logic        we,
    output logic [15:0] inport,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [15:0] scratch_q [8];
    logic [15:0] scratch_d [8];
    logic [15:0] led_q, led_d;
    logic [15:0] timer_q, timer_d;
    logic        stat_exp_q, stat_exp_d;
    logic        stat_ovf_q, stat_ovf_d;
    logic [15:0] sw_meta_q, sw_sync_q;

    logic             wr_scratch_s, wr_led_s, wr_timer_s, wr_status_s, wr_txdata_s;
    logic             timer_expire_s;
    logic             push_drop_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [15:0]      status_s;
    logic [15:0]      rdata_s;

    assign wr_scratch_s = we & is_scratch(dirport);
    assign wr_led_s     = we & (dirport == ADDR_LED);
    assign wr_timer_s   = we & (dirport == ADDR_TIMER);
    assign wr_status_s  = we & (dirport == ADDR_STATUS);
    assign wr_txdata_s  = we & (dirport == ADDR_TXDATA);

    // The expiry event is the 1->0 step itself; it fires even when a timer
    // write replaces the decremented value in the same cycle.
    assign timer_expire_s = (timer_q == 16'd1);
    assign push_drop_s    = wr_txdata_s & fifo_full_s;

    ms_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txdata_s),
        .push_data (outport[7:0]),
        .pop       (tx_ready),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (tx_data),
        .count     (fifo_count_s)
    );

    assign tx_valid = ~fifo_empty_s;
    assign led_out  = led_q;
    assign irq      = stat_exp_q;

    always_comb begin
        status_s                 = 16'd0;
        status_s[STAT_TIMER_EXP] = stat_exp_q;
        status_s[STAT_TX_FULL]   = fifo_full_s;
        status_s[STAT_TX_EMPTY]  = fifo_empty_s;
        status_s[STAT_TX_OVF]    = stat_ovf_q;
    end

    // Next-state for the CPU-visible registers and sticky status bits.
    always_comb begin
        scratch_d  = scratch_q;
        led_d      = led_q;
        timer_d    = timer_q;
        stat_exp_d = stat_exp_q;
        stat_ovf_d = stat_ovf_q;

        if (wr_scratch_s) begin
            scratch_d[dirport[2:0]] = outport;
        end else begin
            scratch_d = scratch_q;
        end

        if (wr_led_s) begin
            led_d = outport;
        end else begin
            led_d = led_q;
        end

        // Load beats decrement; zero holds.
        if (wr_timer_s) begin
            timer_d = outport;
        end else if (timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
        end else begin
            timer_d = timer_q;
        end

        // Sticky bits: a set event outranks a coincident write-1-to-clear.
        if (timer_expire_s) begin
            stat_exp_d = 1'b1;
        end else if (wr_status_s & outport[STAT_TIMER_EXP]) begin
            stat_exp_d = 1'b0;
        end else begin
            stat_exp_d = stat_exp_q;
        end

        if (push_drop_s) begin
            stat_ovf_d = 1'b1;
        end else if (wr_status_s & outport[STAT_TX_OVF]) begin
            stat_ovf_d = 1'b0;
        end else begin
            stat_ovf_d = stat_ovf_q;
        end
    end

    // Register update with synchronous reset; reset overrides any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                scratch_q[i] <= 16'd0;
            end
            scratch_q[0] <= REG0_INIT;
            scratch_q[1] <= REG1_INIT;
            led_q        <= 16'd0;
            timer_q      <= 16'd0;
            stat_exp_q   <= 1'b0;
            stat_ovf_q   <= 1'b0;
            sw_meta_q    <= 16'd0;
            sw_sync_q    <= 16'd0;
        end else begin
            scratch_q    <= scratch_d;
            led_q        <= led_d;
            timer_q      <= timer_d;
            stat_exp_q   <= stat_exp_d;
            stat_ovf_q   <= stat_ovf_d;
            sw_meta_q    <= sw_in;
            sw_sync_q    <= sw_meta_q;
        end
    end

    // Zero-latency read mux; unmapped and write-only addresses read 0.
    always_comb begin
        rdata_s = 16'd0;
        if (is_scratch(dirport)) begin
            rdata_s = scratch_q[dirport[2:0]];
        end else begin
            case (dirport)
                ADDR_SW:      rdata_s = sw_sync_q;
                ADDR_LED:     rdata_s = led_q;
                ADDR_TIMER:   rdata_s = timer_q;
                ADDR_STATUS:  rdata_s = status_s;
                ADDR_TXCOUNT: rdata_s = {{(16-CNT_W){1'b0}}, fifo_count_s};
                default:      rdata_s = 16'd0;
            endcase
        end
    end

    assign inport = rdata_s;

endmodule

// File: tb/tb_ms_io_ports.sv
module tb_ms_io_ports;

    logic        clk;
    logic        reset;
    logic [4:0]  dirport;
    logic [15:0] outport;
    logic        we;
    logic [15:0] inport;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int n_checks;
    int n_errors;

    ms_io_ports #(
        .REG0_INIT  (16'd2),
        .REG1_INIT  (16'd4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dirport  (dirport),
        .outport  (outport),
        .we       (we),
        .inport   (inport),
        .sw_in    (sw_in),
        .led_out  (led_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [15:0] data);
        dirport = addr;
        outport = data;
        we      = 1'b1;
        tick();
        we      = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] addr, input logic [15:0] exp);
        dirport = addr;
        #1;
        check_eq(tag, inport, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        dirport  = 5'h00;
        outport  = 16'h0000;
        we       = 1'b0;
        sw_in    = 16'h0000;
        tx_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        read_chk("rst_scratch0", 5'h00, 16'h0002);
        read_chk("rst_scratch1", 5'h01, 16'h0004);
        read_chk("rst_scratch2", 5'h02, 16'h0000);
        read_chk("rst_status", 5'h0B, 16'h0004);
        read_chk("rst_txcount", 5'h0D, 16'h0000);
        check_eq("rst_led", led_out, 16'h0000);
        check_eq("rst_irq", {15'd0, irq}, 16'h0000);
        check_eq("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);

        // Register writes and unmapped space
        write_reg(5'h09, 16'hA5A5);
        check_eq("led_out", led_out, 16'hA5A5);
        read_chk("led_read", 5'h09, 16'hA5A5);
        write_reg(5'h00, 16'h5555);
        write_reg(5'h07, 16'hBEEF);
        read_chk("scratch0_wr", 5'h00, 16'h5555);
        read_chk("scratch7_wr", 5'h07, 16'hBEEF);
        write_reg(5'h1F, 16'hFFFF);
        read_chk("unmapped_1f", 5'h1F, 16'h0000);
        read_chk("unmapped_0e", 5'h0E, 16'h0000);
        read_chk("txdata_wo", 5'h0C, 16'h0000);

        // Switch synchronizer: two edges of latency
        sw_in = 16'h1234;
        read_chk("sw_edge0", 5'h08, 16'h0000);
        tick();
        read_chk("sw_edge1", 5'h08, 16'h0000);
        tick();
        read_chk("sw_edge2", 5'h08, 16'h1234);

        // Timer countdown and expiry
        write_reg(5'h0A, 16'd3);
        read_chk("timer_load", 5'h0A, 16'd3);
        tick();
        read_chk("timer_2", 5'h0A, 16'd2);
        tick();
        read_chk("timer_1", 5'h0A, 16'd1);
        check_eq("irq_before", {15'd0, irq}, 16'h0000);
        tick();
        read_chk("timer_0", 5'h0A, 16'd0);
        read_chk("status_exp", 5'h0B, 16'h0005);
        check_eq("irq_set", {15'd0, irq}, 16'h0001);
        tick();
        read_chk("timer_hold0", 5'h0A, 16'd0);
        write_reg(5'h0B, 16'h0000);
        check_eq("irq_w0_noclr", {15'd0, irq}, 16'h0001);
        write_reg(5'h0B, 16'h0001);
        check_eq("irq_clr", {15'd0, irq}, 16'h0000);
        read_chk("status_clr", 5'h0B, 16'h0004);

        // Load in the expiry cycle: load wins, flag still set
        write_reg(5'h0A, 16'd2);
        tick();
        read_chk("timer_pre_exp", 5'h0A, 16'd1);
        write_reg(5'h0A, 16'd7);
        read_chk("timer_load_wins", 5'h0A, 16'd7);
        read_chk("status_load_exp", 5'h0B, 16'h0005);
        // Clear in the expiry cycle: set wins
        for (int i = 0; i < 6; i++) tick();
        read_chk("timer_pre_exp2", 5'h0A, 16'd1);
        write_reg(5'h0B, 16'h0001);
        read_chk("status_set_wins", 5'h0B, 16'h0005);
        write_reg(5'h0B, 16'h0001);
        read_chk("status_clr2", 5'h0B, 16'h0004);

        // TX FIFO fill, overflow, drain
        tx_ready = 1'b0;
        write_reg(5'h0C, 16'h0011);
        check_eq("tx_valid_push", {15'd0, tx_valid}, 16'h0001);
        check_eq("tx_head_first", {8'd0, tx_data}, 16'h0011);
        for (int i = 1; i < 5; i++) write_reg(5'h0C, 16'(8'h11 + i));
        read_chk("txcount_full", 5'h0D, 16'd4);
        read_chk("status_full_ovf", 5'h0B, 16'h000A);
        tick();
        check_eq("tx_head_stable", {8'd0, tx_data}, 16'h0011);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_valid", {15'd0, tx_valid}, 16'h0001);
            check_eq("drain_data", {8'd0, tx_data}, 16'(8'h11 + i));
            tick();
        end
        check_eq("drained_valid", {15'd0, tx_valid}, 16'h0000);
        read_chk("drained_count", 5'h0D, 16'd0);
        tx_ready = 1'b0;
        write_reg(5'h0B, 16'h0008);
        read_chk("ovf_clr", 5'h0B, 16'h0004);

        // Simultaneous push and pop when partly full
        write_reg(5'h0C, 16'h0021);
        write_reg(5'h0C, 16'h0022);
        tx_ready = 1'b1;
        write_reg(5'h0C, 16'h0023);
        tx_ready = 1'b0;
        read_chk("pushpop_count", 5'h0D, 16'd2);
        check_eq("pushpop_head", {8'd0, tx_data}, 16'h0022);

        // Push while full with a pop in the same cycle: still dropped
        write_reg(5'h0C, 16'h0024);
        write_reg(5'h0C, 16'h0025);
        read_chk("refill_count", 5'h0D, 16'd4);
        tx_ready = 1'b1;
        write_reg(5'h0C, 16'h0026);
        tx_ready = 1'b0;
        read_chk("drop_count", 5'h0D, 16'd3);
        read_chk("drop_status", 5'h0B, 16'h0008);
        check_eq("drop_head", {8'd0, tx_data}, 16'h0023);

        // Reset during drain with a write pending
        write_reg(5'h0A, 16'd100);
        tx_ready = 1'b1;
        tick();
        reset = 1'b1;
        write_reg(5'h09, 16'hFFFF);
        reset    = 1'b0;
        tx_ready = 1'b0;
        check_eq("rst2_led", led_out, 16'h0000);
        check_eq("rst2_tx_valid", {15'd0, tx_valid}, 16'h0000);
        check_eq("rst2_irq", {15'd0, irq}, 16'h0000);
        read_chk("rst2_txcount", 5'h0D, 16'd0);
        read_chk("rst2_status", 5'h0B, 16'h0004);
        read_chk("rst2_timer", 5'h0A, 16'd0);
        read_chk("rst2_scratch0", 5'h00, 16'h0002);
        read_chk("rst2_scratch7", 5'h07, 16'h0000);
        read_chk("rst2_sw", 5'h08, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ms_io_ports.md
MS_IO_PORTS -- requirements
Module: ms_io_ports

Interface
REQ-001 Parameter: REG0_INIT, 16'd2, reset value of scratch register 0.
REQ-002 Parameter: REG1_INIT, 16'd4, reset value of scratch register 1.
REQ-003 Parameter: FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2).
REQ-004 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: dirport  in  5  port address driven by MaquinaSencilla.
REQ-007 Port: outport  in  16  write data from MaquinaSencilla.
REQ-008 Port: we  in  1  write strobe, qualifies outport at dirport.
REQ-009 Port: inport  out  16  read data returned to MaquinaSencilla.
REQ-010 Port: sw_in  in  16  asynchronous external switches.
REQ-011 Port: led_out  out  16  LED register contents.
REQ-012 Port: tx_data / tx_valid / tx_ready  out 8 / out 1 / in 1  byte stream, valid/ready handshake.
REQ-013 Port: irq  out  1  level copy of status bit0 (timer expired).

Function
REQ-014 Address map SHALL be: 0x00-0x07 scratch RW; 0x08 SW RO; 0x09 LED RW; 0x0A TIMER RW; 0x0B STATUS RW1C; 0x0C TXDATA WO; 0x0D TXCOUNT RO; others read 0, writes ignored.
REQ-015 inport SHALL be combinational from dirport and current register state (zero-latency read); no read side effects.
REQ-016 Writes SHALL take effect on the clock edge where we=1; readback valid the following cycle.
REQ-017 SW SHALL return sw_in through a two-flop synchronizer (2-cycle latency).
REQ-018 TIMER: write loads 16-bit down-counter; counter decrements each cycle while nonzero; transition 1->0 sets STATUS[0]; read returns current count; count 0 holds.
REQ-019 Timer write in the same cycle as 1->0 transition: load wins, STATUS[0] still set.
REQ-020 STATUS read: [0] timer_expired, [1] tx_full, [2] tx_empty, [3] tx_overflow, others 0; writing 1 to bit0 or bit3 clears it; set event same cycle as clear: set wins.
REQ-021 TXDATA write SHALL push outport[7:0] into FIFO if not full at start of cycle; otherwise data dropped and STATUS[3] set (pop same cycle does not rescue it).
REQ-022 FIFO pop on tx_valid & tx_ready; tx_valid = not empty; tx_data = head, stable while tx_valid & !tx_ready.
REQ-023 Push into empty FIFO: tx_valid asserted next cycle; simultaneous push and pop when partly full: count unchanged.
REQ-024 TXCOUNT returns occupancy 0..FIFO_DEPTH, zero-extended; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-025 On reset: scratch0=REG0_INIT, scratch1=REG1_INIT, scratch2-7=0, LED=0, timer=0, STATUS bits=0, FIFO empty (tx_valid=0, TXCOUNT=0), synchronizer flops=0, irq=0.
REQ-026 Reset asserted mid-operation SHALL override any simultaneous write or pop that cycle.

Structure
REQ-027 Shared package SHALL hold address constants (ADDR_SCRATCH0..ADDR_TXCOUNT) and STATUS bit indices.
REQ-028 TX FIFO SHALL be a separate sub-module ms_tx_fifo (push/full, pop/empty, count).

Verification
REQ-029 Reset, read 0x00 and 0x01 -> inport 2 then 4; write 0x09=0xA5A5 -> led_out=0xA5A5 next cycle.
REQ-030 sw_in=0x1234 -> read 0x08 returns 0x1234 after exactly 2 edges, old value before.
REQ-031 Write TIMER=3 -> count 2,1,0; STATUS=0x0005 and irq=1 on 0 cycle; write STATUS=1 -> irq=0.
REQ-032 tx_ready=0, write 5 bytes 0x11..0x15 -> TXCOUNT=4, STATUS[1]=1, STATUS[3]=1; raise tx_ready -> 0x11..0x14 in order, then tx_valid=0.
REQ-033 TIMER load in same cycle as expiry, and STATUS clear coincident with set -> load value kept, STATUS[0]=1.
REQ-034 Reset during FIFO drain with we=1 -> all REQ-025 values next cycle, write discarded.
